pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Central pipeline sequencing controller for the 5-stage MIPS core. It does three things:
- Detects load-use hazards that the ex/mem forwarding paths into the decode stage cannot cover.
- Sequences multi-cycle execute operations (mult/div/madd class) with a cycle counter.
- Handles exception/branch flush requests.

It drives one stall vector read by pc_reg, if_id, id_ex, ex_mem and mem_wb, plus a flush strobe and a saturating stall-cycle counter.

Parameters:
CNT_W, 6, width of multi-cycle length and down-counter (max op length 2^CNT_W-1 cycles)
PERF_W, 32, width of stall performance counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
id_re1_i  in  1  decode read-port-1 enable
id_raddr1_i  in  5  decode read address 1
id_re2_i  in  1  decode read-port-2 enable
id_raddr2_i  in  5  decode read address 2
ex_is_load_i  in  1  instruction currently in ex is a load
ex_waddr_i  in  5  ex destination register
ex_mc_start_i  in  1  ex holds a multi-cycle op in its first cycle
ex_mc_cycles_i  in  CNT_W  total ex cycles of that op
flush_req_i  in  1  exception/redirect request
stall_o  out  6  stall[0]=pc, [1]=if, [2]=id, [3]=ex, [4]=mem, [5]=wb
flush_o  out  1  clear all pipeline registers this cycle
mc_busy_o  out  1  multi-cycle op in progress
mc_last_o  out  1  final cycle of multi-cycle op; ex result valid
mc_cnt_o  out  CNT_W  remaining cycles
stall_cnt_o  out  PERF_W  cycles with any stall bit set, saturating

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, stall_cnt=0. All outputs 0.
- Stall vector rule: stage i stalled and stage i+1 not stalled → bubble (NOP) injected into stage i+1.
- Load-use hazard (combinational):
  - lu = ex_is_load_i & ((id_re1_i & id_raddr1_i==ex_waddr_i) | (id_re2_i & id_raddr2_i==ex_waddr_i)) & ex_waddr_i!=0.
  - Register $0 never causes a hazard.
- FSM states: IDLE, BUSY.
- IDLE:
  - flush_req_i → flush_o=1, stall_o=0.
  - else ex_mc_start_i & ex_mc_cycles_i>=2 → stall_o=6'b001111, cnt<=cycles-1, next BUSY, mc_busy_o=1.
  - else lu → stall_o=6'b000111.
  - else stall_o=0.
  - cycles 0 or 1 → treated as single-cycle; no stall, no state change.
- BUSY:
  - mc_busy_o=1, mc_cnt_o=cnt.
  - cnt>1 → stall_o=6'b001111, cnt<=cnt-1.
  - cnt==1 → stall_o=0, mc_last_o=1, next IDLE.
  - lu and ex_mc_start_i are ignored in BUSY. id is already frozen; lu is re-evaluated in IDLE.
- Op length N therefore stalls exactly N-1 cycles. mc_last_o is high only in cycle N.
- Priority, highest first: flush_req_i > multi-cycle > load-use.
  - flush_req_i in BUSY aborts: next IDLE, cnt<=0, flush_o=1, stall_o=0, mc_last_o=0.
  - flush_o is combinational. It is high in every cycle flush_req_i is high.
- stall_cnt increments each cycle stall_o!=0 and holds at all-ones (saturates, no wrap).
- stall_o, flush_o, mc_last_o are combinational from state and inputs. cnt, state and stall_cnt are registered.
- Reset mid-BUSY: immediate return to IDLE, all outputs 0.

Decomposition:
- Shared define header gets these constants:
  - Stall vector encodings STALL_NONE=6'b000000, STALL_LU=6'b000111, STALL_MC=6'b001111.
  - Stall bit indices.
  - State encodings for IDLE and BUSY.
- One natural sub-module, hazard_detect: the combinational lu term. Everything else stays in pipe_ctrl.

Test Plan:
- Load-use: ex_is_load=1, ex_waddr=5'd3, id_re1=1, id_raddr1=3 → stall_o=6'b000111 that cycle. Same stimulus with ex_waddr=0 → stall_o=0.
- Multi-cycle: ex_mc_start=1, cycles=4 →
  - stall_o=001111 for 3 cycles, with mc_cnt_o 3,2,1 visible in BUSY cycles.
  - 4th cycle: stall_o=0, mc_last_o=1.
  - then IDLE.
- cycles=1 and cycles=0 with ex_mc_start=1 → no stall, mc_busy_o stays 0.
- Flush mid-op: cycles=10, flush_req at BUSY cycle 3 → flush_o=1, stall_o=0, next cycle IDLE with mc_busy_o=0. No mc_last_o pulse.
- Simultaneous lu and mc_start in IDLE → stall_o=001111 (mc wins). lu asserted during BUSY has no effect on stall_o.
- Perf counter: force stall_cnt near max (PERF_W=4 build), hold stall → saturates at 4'hF. Assert rst=0 asynchronously mid-BUSY → all outputs 0 before next clk edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and types for the pipeline sequencing controller.
package pipe_ctrl_pkg;

   // Stall vector bit positions, one per pipeline register.
   localparam int unsigned STALL_PC  = 0;
   localparam int unsigned STALL_IF  = 1;
   localparam int unsigned STALL_ID  = 2;
   localparam int unsigned STALL_EX  = 3;
   localparam int unsigned STALL_MEM = 4;
   localparam int unsigned STALL_WB  = 5;

   // Stall vector encodings: freeze pc..id for load-use, pc..ex for multi-cycle.
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_LU   = 6'b000111;
   localparam logic [5:0] STALL_MC   = 6'b001111;

   // Controller states.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

endpackage : pipe_ctrl_pkg

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detection: a load in ex whose destination is read by decode
// cannot be forwarded in time. Register $0 never creates a hazard.
module pipe_ctrl_hazard_detect (
   input  logic       id_re1_i,
   input  logic [4:0] id_raddr1_i,
   input  logic       id_re2_i,
   input  logic [4:0] id_raddr2_i,
   input  logic       ex_is_load_i,
   input  logic [4:0] ex_waddr_i,
   output logic       lu_o
);

   logic hit1;
   logic hit2;

   // Compare each enabled decode read port against the ex load destination.
   always_comb begin
      hit1 = id_re1_i && (id_raddr1_i == ex_waddr_i);
      hit2 = id_re2_i && (id_raddr2_i == ex_waddr_i);
      lu_o = ex_is_load_i && (hit1 || hit2) && (ex_waddr_i != 5'd0);
   end

endmodule : pipe_ctrl_hazard_detect

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: load-use stalls, multi-cycle execute
// sequencing, flush handling and a saturating stall-cycle counter.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W  = 6,
   parameter int unsigned PERF_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_re1_i,
   input  logic [4:0]        id_raddr1_i,
   input  logic              id_re2_i,
   input  logic [4:0]        id_raddr2_i,
   input  logic              ex_is_load_i,
   input  logic [4:0]        ex_waddr_i,
   input  logic              ex_mc_start_i,
   input  logic [CNT_W-1:0]  ex_mc_cycles_i,
   input  logic              flush_req_i,
   output logic [5:0]        stall_o,
   output logic              flush_o,
   output logic              mc_busy_o,
   output logic              mc_last_o,
   output logic [CNT_W-1:0]  mc_cnt_o,
   output logic [PERF_W-1:0] stall_cnt_o
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
   logic              lu;

   pipe_ctrl_hazard_detect u_hazard_detect (
      .id_re1_i     (id_re1_i),
      .id_raddr1_i  (id_raddr1_i),
      .id_re2_i     (id_re2_i),
      .id_raddr2_i  (id_raddr2_i),
      .ex_is_load_i (ex_is_load_i),
      .ex_waddr_i   (ex_waddr_i),
      .lu_o         (lu)
   );

   // Next-state and combinational outputs; priority flush > multi-cycle > load-use.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_o   = STALL_NONE;
      flush_o   = 1'b0;
      mc_busy_o = 1'b0;
      mc_last_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (flush_req_i) begin
               flush_o = 1'b1;
            end else if (ex_mc_start_i && (ex_mc_cycles_i >= CNT_W'(2))) begin
               stall_o   = STALL_MC;
               mc_busy_o = 1'b1;
               cnt_d     = ex_mc_cycles_i - CNT_W'(1);
               state_d   = ST_BUSY;
            end else if (lu) begin
               stall_o = STALL_LU;
            end
         end
         ST_BUSY: begin
            mc_busy_o = 1'b1;
            if (flush_req_i) begin
               flush_o = 1'b1;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (cnt_q > CNT_W'(1)) begin
               stall_o = STALL_MC;
               cnt_d   = cnt_q - CNT_W'(1);
            end else begin
               mc_last_o = 1'b1;
               cnt_d     = '0;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
      // While reset is held every output reads zero, even the combinational ones.
      if (!rst) begin
         stall_o   = STALL_NONE;
         flush_o   = 1'b0;
         mc_busy_o = 1'b0;
         mc_last_o = 1'b0;
      end
   end

   // Saturating count of cycles with any stall bit set.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((stall_o != STALL_NONE) && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + PERF_W'(1);
      end
   end

   // State, down-counter and performance counter registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign mc_cnt_o    = cnt_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule : pipe_ctrl

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: timestamp-based reference model checked every cycle,
// plus directed literal expectations.
module tb_pipe_ctrl;

   localparam int CNT_W = 6;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             id_re1 = 1'b0, id_re2 = 1'b0;
   logic [4:0]       id_raddr1 = '0, id_raddr2 = '0;
   logic             ex_is_load = 1'b0;
   logic [4:0]       ex_waddr = '0;
   logic             mc_start = 1'b0;
   logic [CNT_W-1:0] mc_cycles = '0;
   logic             flush_req = 1'b0;

   logic [5:0]       stall, stall4;
   logic             flush, busy, last, flush4, busy4, last4;
   logic [CNT_W-1:0] cnt, cnt4;
   logic [31:0]      scnt;
   logic [3:0]       scnt4;

   pipe_ctrl #(.CNT_W(CNT_W), .PERF_W(32)) dut (
      .clk(clk), .rst(rst),
      .id_re1_i(id_re1), .id_raddr1_i(id_raddr1),
      .id_re2_i(id_re2), .id_raddr2_i(id_raddr2),
      .ex_is_load_i(ex_is_load), .ex_waddr_i(ex_waddr),
      .ex_mc_start_i(mc_start), .ex_mc_cycles_i(mc_cycles),
      .flush_req_i(flush_req),
      .stall_o(stall), .flush_o(flush), .mc_busy_o(busy), .mc_last_o(last),
      .mc_cnt_o(cnt), .stall_cnt_o(scnt)
   );

   pipe_ctrl #(.CNT_W(CNT_W), .PERF_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .id_re1_i(id_re1), .id_raddr1_i(id_raddr1),
      .id_re2_i(id_re2), .id_raddr2_i(id_raddr2),
      .ex_is_load_i(ex_is_load), .ex_waddr_i(ex_waddr),
      .ex_mc_start_i(mc_start), .ex_mc_cycles_i(mc_cycles),
      .flush_req_i(flush_req),
      .stall_o(stall4), .flush_o(flush4), .mc_busy_o(busy4), .mc_last_o(last4),
      .mc_cnt_o(cnt4), .stall_cnt_o(scnt4)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // An accepted op of length n started in cycle s occupies cycles s..s+n-1;
   // its last cycle is s+n-1 and remaining count in cycle t is s+n-t.
   int    cyc = 0;
   int    op_s = -1;
   int    op_n = 0;
   longint stalls = 0;

   function automatic logic model_lu();
      logic r;
      r = ex_is_load && (ex_waddr != 0) &&
          ((id_re1 && id_raddr1 == ex_waddr) || (id_re2 && id_raddr2 == ex_waddr));
      return r;
   endfunction

   always @(negedge clk) begin
      logic [5:0] e_stall;
      logic       e_flush, e_busy, e_last, in_op;
      int         e_cnt;
      longint     sat4;
      if (!rst) begin
         op_s = -1;
         stalls = 0;
         chk("rst_stall", stall, 0);
         chk("rst_flush", flush, 0);
         chk("rst_busy", busy, 0);
         chk("rst_last", last, 0);
         chk("rst_cnt", cnt, 0);
         chk("rst_scnt", scnt, 0);
         chk("rst_scnt4", scnt4, 0);
      end else begin
         e_stall = 6'b000000; e_flush = 0; e_busy = 0; e_last = 0; e_cnt = 0;
         in_op = (op_s >= 0) && (cyc > op_s) && (cyc <= op_s + op_n - 1);
         if (in_op) begin
            e_busy = 1;
            e_cnt = op_s + op_n - cyc;
            if (flush_req) begin
               e_flush = 1;
               op_s = -1;
            end else if (cyc < op_s + op_n - 1) begin
               e_stall = 6'b001111;
            end else begin
               e_last = 1;
               op_s = -1;
            end
         end else begin
            if (flush_req) e_flush = 1;
            else if (mc_start && mc_cycles >= 2) begin
               e_stall = 6'b001111; e_busy = 1;
               op_s = cyc; op_n = int'(mc_cycles);
            end else if (model_lu()) e_stall = 6'b000111;
         end
         sat4 = (stalls > 15) ? 15 : stalls;
         chk("stall", stall, e_stall);
         chk("flush", flush, e_flush);
         chk("busy", busy, e_busy);
         chk("last", last, e_last);
         chk("cnt", cnt, e_cnt);
         chk("scnt", scnt, stalls);
         chk("scnt4", scnt4, sat4);
         chk("stall4", stall4, e_stall);
         if (e_stall != 0) stalls++;
      end
      cyc++;
   end

   // ---------------- directed stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      id_re1 = 0; id_re2 = 0; id_raddr1 = 0; id_raddr2 = 0;
      ex_is_load = 0; ex_waddr = 0; mc_start = 0; mc_cycles = 0; flush_req = 0;
   endtask

   initial begin
      step(); step();
      chk("lit_reset_stall", stall, 0);
      chk("lit_reset_scnt", scnt, 0);
      rst = 1;
      step();

      // Load-use on port 1, then $0 destination.
      ex_is_load = 1; ex_waddr = 5'd3; id_re1 = 1; id_raddr1 = 5'd3;
      #2 chk("lit_lu_port1", stall, 6'b000111);
      step();
      ex_waddr = 5'd0; id_raddr1 = 5'd0;
      #2 chk("lit_lu_r0", stall, 6'b000000);
      step();
      // Port 2 hazard, then port disabled.
      id_re1 = 0; id_re2 = 1; id_raddr2 = 5'd9; ex_waddr = 5'd9;
      #2 chk("lit_lu_port2", stall, 6'b000111);
      step();
      id_re2 = 0;
      #2 chk("lit_lu_disabled", stall, 6'b000000);
      step();
      clear_in();

      // Four-cycle op: three stall cycles, mc_last in the fourth.
      mc_start = 1; mc_cycles = 4;
      #2 chk("lit_mc_c1_stall", stall, 6'b001111);
      chk("lit_mc_c1_busy", busy, 1);
      step(); mc_start = 0; mc_cycles = 0;
      #2 chk("lit_mc_c2_cnt", cnt, 3);
      chk("lit_mc_c2_stall", stall, 6'b001111);
      step();
      #2 chk("lit_mc_c3_cnt", cnt, 2);
      step();
      #2 chk("lit_mc_c4_stall", stall, 6'b000000);
      chk("lit_mc_c4_last", last, 1);
      chk("lit_mc_c4_cnt", cnt, 1);
      step();
      #2 chk("lit_mc_done_busy", busy, 0);
      chk("lit_mc_done_last", last, 0);
      step();

      // Degenerate lengths 1 and 0.
      mc_start = 1; mc_cycles = 1;
      #2 chk("lit_mc1_busy", busy, 0);
      chk("lit_mc1_stall", stall, 0);
      step(); mc_cycles = 0;
      #2 chk("lit_mc0_busy", busy, 0);
      step();
      mc_start = 0;
      #2 chk("lit_mc0_after", busy, 0);
      step();

      // Flush in BUSY cycle 3 of a ten-cycle op.
      mc_start = 1; mc_cycles = 10;
      step(); mc_start = 0; mc_cycles = 0;
      step();
      step();
      flush_req = 1;
      #2 chk("lit_fl_cnt", cnt, 7);
      chk("lit_fl_flush", flush, 1);
      chk("lit_fl_stall", stall, 0);
      chk("lit_fl_last", last, 0);
      step(); flush_req = 0;
      #2 chk("lit_fl_after_busy", busy, 0);
      chk("lit_fl_after_stall", stall, 0);
      step();
      // Flush beats load-use and an op start in IDLE.
      flush_req = 1; ex_is_load = 1; ex_waddr = 5'd7; id_re1 = 1; id_raddr1 = 5'd7;
      mc_start = 1; mc_cycles = 5;
      #2 chk("lit_fl_idle_stall", stall, 0);
      chk("lit_fl_idle_flush", flush, 1);
      step(); flush_req = 0; mc_start = 0; mc_cycles = 0;
      #2 chk("lit_fl_idle_nobusy", busy, 0);
      step();

      // Load-use together with op start: op wins; load-use ignored in BUSY.
      mc_start = 1; mc_cycles = 3;
      #2 chk("lit_pri_stall", stall, 6'b001111);
      step(); mc_cycles = 5;
      #2 chk("lit_busy_lu_stall", stall, 6'b001111);
      chk("lit_busy_lu_cnt", cnt, 2);
      step(); mc_start = 0; mc_cycles = 0;
      #2 chk("lit_busy_lu_last", last, 1);
      chk("lit_busy_lu_stall0", stall, 0);
      step();
      #2 chk("lit_idle_lu_again", stall, 6'b000111);
      // Hold the load-use stall long enough to saturate the 4-bit counter.
      repeat (20) step();
      #2 chk("lit_sat4", scnt4, 4'hF);
      step();
      clear_in();
      step();

      // Asynchronous reset in the middle of an op.
      mc_start = 1; mc_cycles = 8;
      step(); mc_start = 0; mc_cycles = 0;
      step();
      #1 chk("lit_pre_rst_busy", busy, 1);
      rst = 0;
      #1 chk("lit_arst_busy", busy, 0);
      chk("lit_arst_stall", stall, 0);
      chk("lit_arst_cnt", cnt, 0);
      chk("lit_arst_scnt", scnt, 0);
      chk("lit_arst_last", last, 0);
      step();
      rst = 1;
      step();
      #2 chk("lit_post_rst_busy", busy, 0);
      step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pipe_ctrl
